// File: rtl/mape_xover.sv
// Multi-word genome crossover/mutation engine: buffers NUM_WORDS words of ctrl/A/B,
// then streams child words over valid/ready with optional LFSR-driven mutation.
module mape_xover #(
  parameter int                  WORD_SZ   = 64,
  parameter int                  NUM_WORDS = 4,
  parameter int                  ADDR_W    = $clog2(NUM_WORDS),
  parameter logic [WORD_SZ-1:0]  LFSR_TAPS = 64'hD800000000000000,
  parameter logic [WORD_SZ-1:0]  LFSR_SEED = 64'h1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         wr_mode,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WORD_SZ-1:0] data_in,
  input  logic               mut_en,
  input  logic [WORD_SZ-1:0] mut_bias,
  input  logic               start,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_SZ-1:0] data_out,
  output logic               done
);

  // state  | meaning
  // S_IDLE | buffers writable, waiting for start
  // S_RUN  | streaming child words, buffers frozen
  // S_DONE | one-cycle done pulse, then back to idle
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WORD_SZ-1:0]   ctrl_q [NUM_WORDS];
  logic [WORD_SZ-1:0]   ctrl_d [NUM_WORDS];
  logic [WORD_SZ-1:0]   a_q    [NUM_WORDS];
  logic [WORD_SZ-1:0]   a_d    [NUM_WORDS];
  logic [WORD_SZ-1:0]   b_q    [NUM_WORDS];
  logic [WORD_SZ-1:0]   b_d    [NUM_WORDS];
  logic [ADDR_W:0]      idx_q, idx_d;
  logic [WORD_SZ-1:0]   lfsr_q, lfsr_d;
  logic                 mut_en_q, mut_en_d;
  logic [WORD_SZ-1:0]   mut_bias_q, mut_bias_d;
  logic [WORD_SZ-1:0]   data_out_q, data_out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic [WORD_SZ-1:0]   lfsr_step;
  logic [ADDR_W-1:0]    rd_idx;
  logic                 mut_en_eff;
  logic [WORD_SZ-1:0]   mut_bias_eff;
  logic [WORD_SZ-1:0]   mut_mask;
  logic [WORD_SZ-1:0]   child;
  logic                 wr_addr_ok;
  logic                 idx_more;

  assign lfsr_step  = {1'b0, lfsr_q[WORD_SZ-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  assign wr_addr_ok = 32'(wr_addr) < NUM_WORDS;
  assign idx_more   = 32'(idx_q) < NUM_WORDS;

  // Word 0 is computed in the start cycle, so it must see the live mutation inputs.
  always_comb begin
    if (state_q == S_IDLE) begin
      rd_idx       = '0;
      mut_en_eff   = mut_en;
      mut_bias_eff = mut_bias;
    end else begin
      rd_idx       = idx_q[ADDR_W-1:0];
      mut_en_eff   = mut_en_q;
      mut_bias_eff = mut_bias_q;
    end
    mut_mask = mut_en_eff ? (lfsr_q & mut_bias_eff) : '0;
    child    = ((ctrl_q[rd_idx] & a_q[rd_idx]) | (~ctrl_q[rd_idx] & b_q[rd_idx])) ^ mut_mask;
  end

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    lfsr_d      = lfsr_q;
    mut_en_d    = mut_en_q;
    mut_bias_d  = mut_bias_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mut_en_d    = mut_en;
          mut_bias_d  = mut_bias;
          data_out_d  = child;
          idx_d       = (ADDR_W+1)'(1);
          out_valid_d = 1'b1;
          lfsr_d      = lfsr_step;
          state_d     = S_RUN;
        end else if (wr_addr_ok) begin
          case (wr_mode)
            2'b01:   ctrl_d[wr_addr] = data_in;
            2'b10:   a_d[wr_addr]    = data_in;
            2'b11:   b_d[wr_addr]    = data_in;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (out_valid_q && out_ready) begin
          if (idx_more) begin
            data_out_d = child;
            idx_d      = idx_q + 1'b1;
            lfsr_d     = lfsr_step;
          end else begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NUM_WORDS; i++) begin
        ctrl_q[i] <= '0;
        a_q[i]    <= '0;
        b_q[i]    <= '0;
      end
      idx_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      mut_en_q    <= 1'b0;
      mut_bias_q  <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      lfsr_q      <= lfsr_d;
      mut_en_q    <= mut_en_d;
      mut_bias_q  <= mut_bias_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mape_xover.sv
// Randomized bench for mape_xover: a genome/LFSR reference model predicts every child word.
module tb_mape_xover;
  localparam int W  = 64;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam logic [W-1:0] TAPS = 64'hD800000000000000;
  localparam logic [W-1:0] SEED = 64'h1;
  localparam logic [W-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    wr_mode;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  data_in;
  logic          mut_en;
  logic [W-1:0]  mut_bias;
  logic          start;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  data_out;
  logic          done;

  always #5 clk = ~clk;

  mape_xover dut (
    .clk(clk), .rst(rst), .wr_mode(wr_mode), .wr_addr(wr_addr), .data_in(data_in),
    .mut_en(mut_en), .mut_bias(mut_bias), .start(start), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .done(done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] m_ctrl [N];
  logic [W-1:0] m_a    [N];
  logic [W-1:0] m_b    [N];
  logic [W-1:0] m_lfsr;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_ctrl[i] = '0; m_a[i] = '0; m_b[i] = '0;
    end
    m_lfsr = SEED;
  endtask

  task automatic write_word(input logic [1:0] m, input int addr, input logic [W-1:0] d);
    wr_mode = m; wr_addr = addr[AW-1:0]; data_in = d;
    tick();
    wr_mode = 2'b00;
    case (m)
      2'b01: m_ctrl[addr] = d;
      2'b10: m_a[addr]    = d;
      2'b11: m_b[addr]    = d;
      default: ;
    endcase
  endtask

  task automatic load_all(input logic [W-1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < N; i++) begin
      write_word(2'b01, i, c);
      write_word(2'b10, i, a);
      write_word(2'b11, i, b);
    end
  endtask

  task automatic load_rand();
    for (int i = 0; i < N; i++) begin
      write_word(2'b01, i, rnd64());
      write_word(2'b10, i, rnd64());
      write_word(2'b11, i, rnd64());
    end
  endtask

  // rmode: 0 ready held high, 1 ready toggles 1/0, 2 random ready.
  // noise: write collides with start, then random writes/starts throughout the run.
  task automatic run(input logic men, input logic [W-1:0] bias, input int rmode, input bit noise);
    logic [W-1:0] exp_w [N];
    logic [W-1:0] held;
    int got;
    int cyc;
    for (int i = 0; i < N; i++) begin
      exp_w[i] = ((m_ctrl[i] & m_a[i]) | (~m_ctrl[i] & m_b[i])) ^ (men ? (m_lfsr & bias) : '0);
      m_lfsr   = lfsr_next(m_lfsr);
    end
    mut_en = men; mut_bias = bias; start = 1'b1;
    if (noise) begin
      wr_mode = 2'b01; wr_addr = AW'($urandom_range(0, N-1)); data_in = rnd64();
    end
    tick();
    start = 1'b0; wr_mode = 2'b00;
    mut_en = 1'($urandom); mut_bias = rnd64();
    chk("busy_run", busy, 1);
    chk("valid_run", out_valid, 1);
    got = 0; cyc = 0;
    while (got < N && cyc < 100) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (noise) begin
        wr_mode = 2'($urandom_range(1, 3)); wr_addr = AW'($urandom);
        data_in = rnd64(); start = 1'($urandom_range(0, 1));
      end
      if (out_valid && out_ready) begin
        chk($sformatf("word%0d", got), data_out, exp_w[got]);
        got++;
      end
      held = data_out;
      tick();
      cyc++;
      if (!out_ready && got < N) begin
        chk("hold_data", data_out, held);
        chk("hold_valid", out_valid, 1);
      end
    end
    start = 1'b0; wr_mode = 2'b00;
    chk("handshakes", got, N);
    if (rmode == 0) chk("latency", cyc, N);
    chk("done_pulse", done, 1);
    chk("valid_off", out_valid, 0);
    chk("busy_done", busy, 1);
    out_ready = 1'($urandom);
    tick();
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1; wr_mode = 2'b00; wr_addr = '0; data_in = '0;
    mut_en = 1'b0; mut_bias = '0; start = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_out, 0);

    // pure crossover, ready high then toggling
    load_all(64'hFFFF_FFFF_0000_0000, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    run(1'b0, '0, 0, 1'b0);
    run(1'b0, '0, 1, 1'b0);

    // mutation only: words are successive LFSR states
    load_all('0, '0, '0);
    run(1'b1, ONES, 0, 1'b0);

    // zero bias still advances the LFSR, seen in the following run
    load_rand();
    run(1'b1, '0, 0, 1'b0);
    run(1'b1, ONES, 0, 1'b0);

    // ignored writes/starts during run and colliding with start
    load_rand();
    run(1'b1, rnd64(), 2, 1'b1);
    run(1'b1, rnd64(), 0, 1'b0);

    // reset after two accepted words
    mut_en = 1'b1; mut_bias = ONES; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("abort_valid", out_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_data", data_out, 0);
    chk("abort_busy", busy, 0);
    run(1'b1, ONES, 0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      load_rand();
      run(1'($urandom), rnd64(), $urandom_range(0, 2), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
